// File: rtl/scan_select_mux.sv
// Registered multi-channel selector with a shared select register that is
// loaded manually, auto-scans up or down at a fixed divided rate, or freezes.
// Every channel picks the same input index; out lags the select by one edge.
//
// Parameter constraints, which the design assumes and does not check:
//   NUM_IN >= 2, SCAN_DIV >= 1, 2**SEL_W >= NUM_IN.
module scan_select_mux #(
    parameter int unsigned NUM_CH   = 3,
    parameter int unsigned NUM_IN   = 5,
    parameter int unsigned W        = 1,
    parameter int unsigned SCAN_DIV = 4,
    parameter int unsigned SEL_W    = 3
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_CH*NUM_IN*W-1:0] data_in,
    input  logic [SEL_W-1:0]           sel_in,
    input  logic                       load,
    input  logic [1:0]                 mode,
    output logic [NUM_CH*W-1:0]        out,
    output logic [SEL_W-1:0]           cur_sel,
    output logic                       sel_err,
    output logic                       tick
);

    typedef enum logic [1:0] {
        ModeManual   = 2'b00,
        ModeScanUp   = 2'b01,
        ModeScanDown = 2'b10,
        ModeFreeze   = 2'b11
    } mode_e;

    // A divider of 1 still needs a one-bit counter that simply sits at zero.
    localparam int unsigned DivW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    localparam logic [SEL_W-1:0] SelLast = SEL_W'(NUM_IN - 1);
    localparam logic [DivW-1:0]  DivLast = DivW'(SCAN_DIV - 1);

    mode_e                mode_cur;
    logic [1:0]           mode_q;
    logic                 mode_chg;

    logic [SEL_W-1:0]     sel_q, sel_d;
    logic [DivW-1:0]      div_q, div_d;
    logic                 err_q, err_d;
    logic                 tick_q, tick_d;
    logic [NUM_CH*W-1:0]  out_q, out_d;
    logic [NUM_CH*W-1:0]  mux;

    assign mode_cur = mode_e'(mode);
    // Any mode edge restarts the divider so a fresh scan always waits a full period.
    assign mode_chg = (mode != mode_q);

    // Select, divider, error flag and step pulse: reset > load > auto-step > hold.
    always_comb begin
        sel_d  = sel_q;
        div_d  = div_q;
        err_d  = err_q;
        tick_d = 1'b0;
        if (load) begin
            div_d = '0;
            if (sel_in <= SelLast) begin
                sel_d = sel_in;
                err_d = 1'b0;
            end else begin
                err_d = 1'b1;
            end
        end else if (mode_chg) begin
            div_d = '0;
        end else begin
            unique case (mode_cur)
                ModeManual: begin
                    div_d = '0;
                end
                ModeScanUp, ModeScanDown: begin
                    if (div_q == DivLast) begin
                        div_d  = '0;
                        tick_d = 1'b1;
                        if (mode_cur == ModeScanUp) begin
                            sel_d = (sel_q == SelLast) ? '0 : sel_q + 1'b1;
                        end else begin
                            sel_d = (sel_q == '0) ? SelLast : sel_q - 1'b1;
                        end
                    end else begin
                        div_d = div_q + 1'b1;
                    end
                end
                ModeFreeze: begin
                    div_d = div_q;
                end
            endcase
        end
    end

    // Per-channel input selection by the current (pre-edge) select value.
    always_comb begin
        mux = '0;
        for (int c = 0; c < int'(NUM_CH); c++) begin
            for (int i = 0; i < int'(NUM_IN); i++) begin
                if (sel_q == SEL_W'(i)) begin
                    mux[c*W +: W] = data_in[(c*int'(NUM_IN) + i)*int'(W) +: W];
                end
            end
        end
    end

    // Output stage holds its value for as long as the mode input requests freeze.
    always_comb begin
        out_d = (mode_cur == ModeFreeze) ? out_q : mux;
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            sel_q  <= '0;
            div_q  <= '0;
            mode_q <= 2'b00;
            err_q  <= 1'b0;
            tick_q <= 1'b0;
            out_q  <= '0;
        end else begin
            sel_q  <= sel_d;
            div_q  <= div_d;
            mode_q <= mode;
            err_q  <= err_d;
            tick_q <= tick_d;
            out_q  <= out_d;
        end
    end

    assign out     = out_q;
    assign cur_sel = sel_q;
    assign sel_err = err_q;
    assign tick    = tick_q;

endmodule
